uart_fifo_core: RTL and testbench

Parametrised UART core: one transmitter, one receiver, a shared 16x-oversampling baud-tick generator, and independent TX and RX FIFOs. Character width, parity, stop bits, baud divisor and FIFO depths are configurable. The receiver adds parity, framing and overrun error reporting. It sits between the CPU-side data path and the board TXD/RXD pins, and replaces the fixed 8N1 top-level UART.

---
 rtl/uart_pkg.sv | 39 +++
 rtl/uart_fifo.sv | 87 ++++++++
 rtl/uart_fifo_core.sv | 314 +++++++++++++++++++++++++++++++
 tb/tb_uart_fifo_core.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART core: parity codes, FSM encodings,
// oversampling constants and the parity helper.
package uart_pkg;

   localparam int OVERSAMPLE   = 16;
   localparam int START_SAMPLE = 8;

   localparam logic [1:0] PAR_NONE = 2'd0;
   localparam logic [1:0] PAR_ODD  = 2'd1;
   localparam logic [1:0] PAR_EVEN = 2'd2;

   typedef enum logic [2:0] {
      TX_IDLE   = 3'd0,
      TX_START  = 3'd1,
      TX_DATA   = 3'd2,
      TX_PARITY = 3'd3,
      TX_STOP   = 3'd4
   } tx_state_t;

   typedef enum logic [2:0] {
      RX_IDLE   = 3'd0,
      RX_START  = 3'd1,
      RX_DATA   = 3'd2,
      RX_PARITY = 3'd3,
      RX_STOP   = 3'd4
   } rx_state_t;

   // Unused upper bits must be zero; they do not disturb the XOR reduction.
   function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] mode);
      logic p;
      p = ^data;
      case (mode)
         PAR_ODD:  parity_bit = ~p;
         PAR_EVEN: parity_bit = p;
         default:  parity_bit = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/uart_fifo.sv
// Circular-buffer FIFO with first-word-fall-through read port and
// registered full/empty flags; pointers carry one wrap bit.
module uart_fifo
   import uart_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW:0]      wptr_r;
   logic [AW:0]      rptr_r;
   logic [AW:0]      wptr_nx_s;
   logic [AW:0]      rptr_nx_s;
   logic             full_r;
   logic             empty_r;
   logic             full_nx_s;
   logic             empty_nx_s;
   logic             do_wr_s;
   logic             do_rd_s;

   // A write while full only lands when a read frees the slot in the same cycle.
   always_comb begin
      do_rd_s = rd & ~empty_r;
      do_wr_s = wr & (~full_r | do_rd_s);
      if (do_wr_s) begin
         wptr_nx_s = wptr_r + PTR_ONE;
      end else begin
         wptr_nx_s = wptr_r;
      end
      if (do_rd_s) begin
         rptr_nx_s = rptr_r + PTR_ONE;
      end else begin
         rptr_nx_s = rptr_r;
      end
      empty_nx_s = (wptr_nx_s == rptr_nx_s);
      full_nx_s  = (wptr_nx_s[AW] != rptr_nx_s[AW]) &&
                   (wptr_nx_s[AW-1:0] == rptr_nx_s[AW-1:0]);
   end

   // Pointer and flag state.
   always_ff @(posedge clk) begin
      if (reset) begin
         wptr_r  <= '0;
         rptr_r  <= '0;
         full_r  <= 1'b0;
         empty_r <= 1'b1;
      end else begin
         wptr_r  <= wptr_nx_s;
         rptr_r  <= rptr_nx_s;
         full_r  <= full_nx_s;
         empty_r <= empty_nx_s;
      end
   end

   // Storage array.
   always_ff @(posedge clk) begin
      if (do_wr_s) begin
         mem_r[wptr_r[AW-1:0]] <= wr_data;
      end
   end

   // Head entry, forced to zero while empty.
   always_comb begin
      if (empty_r) begin
         rd_data = {WIDTH{1'b0}};
      end else begin
         rd_data = mem_r[rptr_r[AW-1:0]];
      end
   end

   assign full  = full_r;
   assign empty = empty_r;

endmodule

// File: rtl/uart_fifo_core.sv
// UART core: shared 16x baud tick, TX/RX FSMs with parity and framing checks,
// and independent TX/RX FIFOs.
module uart_fifo_core
   import uart_pkg::*;
#(
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1,
   parameter int BAUD_DIV  = 27,
   parameter int TX_DEPTH  = 16,
   parameter int RX_DEPTH  = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 tx_wr,
   input  logic [DATA_BITS-1:0] tx_data,
   output logic                 tx_full,
   output logic                 tx_empty,
   output logic                 tx_busy,
   output logic                 txd,
   input  logic                 rxd,
   input  logic                 rx_rd,
   output logic                 rx_valid,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_parity_err,
   output logic                 rx_frame_err,
   output logic                 rx_overrun,
   input  logic                 err_clr
);

   localparam logic [1:0]    PAR_MODE   = 2'(PARITY);
   localparam int            BW         = $clog2(BAUD_DIV);
   localparam logic [BW-1:0] BAUD_LAST  = BW'(BAUD_DIV - 1);
   localparam logic [BW-1:0] BAUD_ONE   = BW'(1);
   localparam logic [4:0]    TX_BIT_END = 5'(OVERSAMPLE - 1);
   localparam logic [4:0]    TX_STOP_END = 5'(OVERSAMPLE * STOP_BITS - 1);
   localparam logic [3:0]    RX_BIT_END = 4'(OVERSAMPLE - 1);
   localparam logic [3:0]    RX_HALF_END = 4'(START_SAMPLE - 1);
   localparam logic [2:0]    LAST_DATA  = 3'(DATA_BITS - 1);

   logic [BW-1:0]        baud_cnt_r;
   logic                 tick_s;

   logic [DATA_BITS-1:0] tx_head_s;
   logic                 tx_pop_s;
   tx_state_t            tx_state_r;
   logic [DATA_BITS-1:0] tx_shift_r;
   logic                 tx_par_r;
   logic [2:0]           tx_bit_r;
   logic [4:0]           tx_tcnt_r;
   logic                 txd_r;
   logic                 tx_busy_r;

   logic                 rx_sync1_r;
   logic                 rx_sync2_r;
   rx_state_t            rx_state_r;
   logic [DATA_BITS-1:0] rx_shift_r;
   logic [2:0]           rx_bit_r;
   logic [3:0]           rx_tcnt_r;
   logic                 rx_perr_r;
   logic                 rx_push_s;
   logic [DATA_BITS+1:0] rx_push_data_s;
   logic [DATA_BITS+1:0] rx_head_s;
   logic                 rx_full_s;
   logic                 rx_empty_s;
   logic                 overrun_s;
   logic                 rx_overrun_r;

   assign tick_s = (baud_cnt_r == BAUD_LAST);

   // Free-running oversample divider.
   always_ff @(posedge clk) begin
      if (reset) begin
         baud_cnt_r <= '0;
      end else if (tick_s) begin
         baud_cnt_r <= '0;
      end else begin
         baud_cnt_r <= baud_cnt_r + BAUD_ONE;
      end
   end

   // Pop when a frame can start: from IDLE, or straight out of the last stop tick.
   always_comb begin
      tx_pop_s = 1'b0;
      if (tick_s && !tx_empty && tx_state_r == TX_IDLE) begin
         tx_pop_s = 1'b1;
      end else if (tick_s && !tx_empty && tx_state_r == TX_STOP && tx_tcnt_r == TX_STOP_END) begin
         tx_pop_s = 1'b1;
      end else begin
         tx_pop_s = 1'b0;
      end
   end

   uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(TX_DEPTH)) u_tx_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr      (tx_wr),
      .wr_data (tx_data),
      .rd      (tx_pop_s),
      .rd_data (tx_head_s),
      .full    (tx_full),
      .empty   (tx_empty)
   );

   // Transmit FSM; txd and tx_busy are registered here.
   always_ff @(posedge clk) begin
      if (reset) begin
         tx_state_r <= TX_IDLE;
         tx_shift_r <= '0;
         tx_par_r   <= 1'b0;
         tx_bit_r   <= 3'd0;
         tx_tcnt_r  <= 5'd0;
         txd_r      <= 1'b1;
         tx_busy_r  <= 1'b0;
      end else if (tick_s) begin
         case (tx_state_r)
            TX_IDLE: begin
               if (tx_pop_s) begin
                  tx_shift_r <= tx_head_s;
                  tx_par_r   <= parity_bit(8'(tx_head_s), PAR_MODE);
                  tx_tcnt_r  <= 5'd0;
                  txd_r      <= 1'b0;
                  tx_busy_r  <= 1'b1;
                  tx_state_r <= TX_START;
               end
            end
            TX_START: begin
               if (tx_tcnt_r == TX_BIT_END) begin
                  tx_tcnt_r  <= 5'd0;
                  tx_bit_r   <= 3'd0;
                  txd_r      <= tx_shift_r[0];
                  tx_state_r <= TX_DATA;
               end else begin
                  tx_tcnt_r <= tx_tcnt_r + 5'd1;
               end
            end
            TX_DATA: begin
               if (tx_tcnt_r == TX_BIT_END) begin
                  tx_tcnt_r <= 5'd0;
                  if (tx_bit_r != LAST_DATA) begin
                     tx_bit_r   <= tx_bit_r + 3'd1;
                     tx_shift_r <= tx_shift_r >> 1;
                     txd_r      <= tx_shift_r[1];
                  end else if (PAR_MODE != PAR_NONE) begin
                     txd_r      <= tx_par_r;
                     tx_state_r <= TX_PARITY;
                  end else begin
                     txd_r      <= 1'b1;
                     tx_state_r <= TX_STOP;
                  end
               end else begin
                  tx_tcnt_r <= tx_tcnt_r + 5'd1;
               end
            end
            TX_PARITY: begin
               if (tx_tcnt_r == TX_BIT_END) begin
                  tx_tcnt_r  <= 5'd0;
                  txd_r      <= 1'b1;
                  tx_state_r <= TX_STOP;
               end else begin
                  tx_tcnt_r <= tx_tcnt_r + 5'd1;
               end
            end
            TX_STOP: begin
               if (tx_tcnt_r == TX_STOP_END) begin
                  tx_tcnt_r <= 5'd0;
                  if (tx_pop_s) begin
                     tx_shift_r <= tx_head_s;
                     tx_par_r   <= parity_bit(8'(tx_head_s), PAR_MODE);
                     txd_r      <= 1'b0;
                     tx_state_r <= TX_START;
                  end else begin
                     tx_busy_r  <= 1'b0;
                     tx_state_r <= TX_IDLE;
                  end
               end else begin
                  tx_tcnt_r <= tx_tcnt_r + 5'd1;
               end
            end
            default: begin
               txd_r      <= 1'b1;
               tx_busy_r  <= 1'b0;
               tx_state_r <= TX_IDLE;
            end
         endcase
      end
   end

   assign txd     = txd_r;
   assign tx_busy = tx_busy_r;

   // Two-flop synchronizer for the asynchronous serial input; idles high.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_sync1_r <= 1'b1;
         rx_sync2_r <= 1'b1;
      end else begin
         rx_sync1_r <= rxd;
         rx_sync2_r <= rx_sync1_r;
      end
   end

   // Receive FSM: mid-bit sampling, START re-check rejects short glitches.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_state_r <= RX_IDLE;
         rx_shift_r <= '0;
         rx_bit_r   <= 3'd0;
         rx_tcnt_r  <= 4'd0;
         rx_perr_r  <= 1'b0;
      end else if (tick_s) begin
         case (rx_state_r)
            RX_IDLE: begin
               if (!rx_sync2_r) begin
                  rx_tcnt_r  <= 4'd0;
                  rx_state_r <= RX_START;
               end
            end
            RX_START: begin
               if (rx_tcnt_r == RX_HALF_END) begin
                  rx_tcnt_r <= 4'd0;
                  rx_bit_r  <= 3'd0;
                  rx_perr_r <= 1'b0;
                  if (rx_sync2_r) begin
                     rx_state_r <= RX_IDLE;
                  end else begin
                     rx_state_r <= RX_DATA;
                  end
               end else begin
                  rx_tcnt_r <= rx_tcnt_r + 4'd1;
               end
            end
            RX_DATA: begin
               if (rx_tcnt_r == RX_BIT_END) begin
                  rx_tcnt_r  <= 4'd0;
                  rx_shift_r <= {rx_sync2_r, rx_shift_r[DATA_BITS-1:1]};
                  if (rx_bit_r != LAST_DATA) begin
                     rx_bit_r <= rx_bit_r + 3'd1;
                  end else if (PAR_MODE != PAR_NONE) begin
                     rx_state_r <= RX_PARITY;
                  end else begin
                     rx_state_r <= RX_STOP;
                  end
               end else begin
                  rx_tcnt_r <= rx_tcnt_r + 4'd1;
               end
            end
            RX_PARITY: begin
               if (rx_tcnt_r == RX_BIT_END) begin
                  rx_tcnt_r  <= 4'd0;
                  rx_perr_r  <= rx_sync2_r ^ parity_bit(8'(rx_shift_r), PAR_MODE);
                  rx_state_r <= RX_STOP;
               end else begin
                  rx_tcnt_r <= rx_tcnt_r + 4'd1;
               end
            end
            RX_STOP: begin
               if (rx_tcnt_r == RX_BIT_END) begin
                  rx_tcnt_r  <= 4'd0;
                  rx_state_r <= RX_IDLE;
               end else begin
                  rx_tcnt_r <= rx_tcnt_r + 4'd1;
               end
            end
            default: begin
               rx_tcnt_r  <= 4'd0;
               rx_state_r <= RX_IDLE;
            end
         endcase
      end
   end

   // The push coincides with the first stop-bit sample; a low stop bit is a framing error.
   always_comb begin
      rx_push_s      = 1'b0;
      rx_push_data_s = {~rx_sync2_r, rx_perr_r, rx_shift_r};
      if (tick_s && rx_state_r == RX_STOP && rx_tcnt_r == RX_BIT_END) begin
         rx_push_s = 1'b1;
      end else begin
         rx_push_s = 1'b0;
      end
   end

   assign overrun_s = rx_push_s & rx_full_s & ~rx_rd;

   uart_fifo #(.WIDTH(DATA_BITS + 2), .DEPTH(RX_DEPTH)) u_rx_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr      (rx_push_s),
      .wr_data (rx_push_data_s),
      .rd      (rx_rd),
      .rd_data (rx_head_s),
      .full    (rx_full_s),
      .empty   (rx_empty_s)
   );

   // Sticky overrun; a new overrun wins over a same-cycle clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_overrun_r <= 1'b0;
      end else if (overrun_s) begin
         rx_overrun_r <= 1'b1;
      end else if (err_clr) begin
         rx_overrun_r <= 1'b0;
      end
   end

   assign rx_valid      = ~rx_empty_s;
   assign rx_data       = rx_head_s[DATA_BITS-1:0];
   assign rx_parity_err = rx_head_s[DATA_BITS];
   assign rx_frame_err  = rx_head_s[DATA_BITS+1];
   assign rx_overrun    = rx_overrun_r;

endmodule

// File: tb/tb_uart_fifo_core.sv
// Scoreboard bench for uart_fifo_core: an 8N1 instance and a 7E2 instance,
// both at BAUD_DIV=4 (one bit = 64 clk).
module tb_uart_fifo_core;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic       a_tx_wr, a_tx_full, a_tx_empty, a_tx_busy, a_txd, a_rxd, a_rx_rd;
   logic [7:0] a_tx_data, a_rx_data;
   logic       a_rx_valid, a_pe, a_fe, a_ovr, a_err_clr, a_loop, a_drv;
   logic       p_tx_wr, p_tx_full, p_tx_empty, p_tx_busy, p_txd, p_rxd, p_rx_rd;
   logic [6:0] p_tx_data, p_rx_data;
   logic       p_rx_valid, p_pe, p_fe, p_ovr, p_err_clr, p_loop, p_drv;
   logic       mon_sel, mon_txd, mon_busy;

   assign a_rxd    = a_loop ? a_txd : a_drv;
   assign p_rxd    = p_loop ? p_txd : p_drv;
   assign mon_txd  = mon_sel ? p_txd : a_txd;
   assign mon_busy = mon_sel ? p_tx_busy : a_tx_busy;

   uart_fifo_core #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .BAUD_DIV(4),
                    .TX_DEPTH(16), .RX_DEPTH(16)) dut_a (
      .clk(clk), .reset(reset), .tx_wr(a_tx_wr), .tx_data(a_tx_data),
      .tx_full(a_tx_full), .tx_empty(a_tx_empty), .tx_busy(a_tx_busy), .txd(a_txd),
      .rxd(a_rxd), .rx_rd(a_rx_rd), .rx_valid(a_rx_valid), .rx_data(a_rx_data),
      .rx_parity_err(a_pe), .rx_frame_err(a_fe), .rx_overrun(a_ovr), .err_clr(a_err_clr));

   uart_fifo_core #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .BAUD_DIV(4),
                    .TX_DEPTH(16), .RX_DEPTH(16)) dut_p (
      .clk(clk), .reset(reset), .tx_wr(p_tx_wr), .tx_data(p_tx_data),
      .tx_full(p_tx_full), .tx_empty(p_tx_empty), .tx_busy(p_tx_busy), .txd(p_txd),
      .rxd(p_rxd), .rx_rd(p_rx_rd), .rx_valid(p_rx_valid), .rx_data(p_rx_data),
      .rx_parity_err(p_pe), .rx_frame_err(p_fe), .rx_overrun(p_ovr), .err_clr(p_err_clr));

   int          n_total = 0;
   int          n_bad   = 0;
   logic [31:0] exp_a[$];
   logic [31:0] exp_p[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_total++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   function automatic logic [31:0] pack(input logic fe, input logic pe, input logic [7:0] d);
      return 32'({fe, pe, d});
   endfunction

   // Expected line bits, index 0 = start bit; stop bits are the trailing ones.
   function automatic logic [15:0] frame_bits(input logic [7:0] d, input int nb, input int par);
      logic [15:0] b;
      b    = 16'hFFFF;
      b[0] = 1'b0;
      for (int i = 0; i < nb; i++) b[1 + i] = d[i];
      if (par == 1) b[1 + nb] = ~(^d);
      else if (par == 2) b[1 + nb] = ^d;
      return b;
   endfunction

   task automatic wait_start(input string tag);
      int n;
      n = 0;
      while (mon_txd !== 1'b0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_start_seen"}, 32'(mon_txd), 32'd0);
   endtask

   task automatic check_bits(input string tag, input logic [15:0] bits, input int len, input bit end_chk);
      for (int k = 0; k < len; k++) begin
         repeat (32) @(negedge clk);
         chk($sformatf("%s_bit%0d", tag, k), 32'(mon_txd), 32'(bits[k]));
         if (end_chk && k == len - 1) begin
            repeat (31) @(negedge clk);
            chk({tag, "_busy_last"}, 32'(mon_busy), 32'd1);
            @(negedge clk);
            chk({tag, "_busy_done"}, 32'(mon_busy), 32'd0);
         end else begin
            repeat (32) @(negedge clk);
         end
      end
   endtask

   task automatic drive_bits(input bit sel, input logic [15:0] bits, input int len);
      for (int k = 0; k < len; k++) begin
         if (sel) p_drv = bits[k]; else a_drv = bits[k];
         repeat (64) @(negedge clk);
      end
      if (sel) p_drv = 1'b1; else a_drv = 1'b1;
   endtask

   task automatic drain(input bit sel, input int n);
      logic [31:0] got, want;
      int w;
      for (int i = 0; i < n; i++) begin
         w = 0;
         while (!(sel ? p_rx_valid : a_rx_valid) && w < 3000) begin
            @(negedge clk);
            w++;
         end
         chk("rx_valid", 32'(sel ? p_rx_valid : a_rx_valid), 32'd1);
         got = sel ? pack(p_fe, p_pe, {1'b0, p_rx_data}) : pack(a_fe, a_pe, a_rx_data);
         if (sel) want = (exp_p.size() > 0) ? exp_p.pop_front() : 32'hDEAD;
         else     want = (exp_a.size() > 0) ? exp_a.pop_front() : 32'hDEAD;
         chk($sformatf("rx_word%0d", i), got, want);
         if (sel) p_rx_rd = 1'b1; else a_rx_rd = 1'b1;
         @(negedge clk);
         p_rx_rd = 1'b0;
         a_rx_rd = 1'b0;
      end
   endtask

   task automatic write_a(input logic [7:0] d);
      a_tx_data = d;
      a_tx_wr   = 1'b1;
      @(negedge clk);
      a_tx_wr   = 1'b0;
   endtask

   initial begin
      logic [15:0] fb;
      int          w;
      reset = 1'b1;
      a_tx_wr = 1'b0; a_tx_data = 8'h00; a_rx_rd = 1'b0; a_err_clr = 1'b0; a_loop = 1'b1; a_drv = 1'b1;
      p_tx_wr = 1'b0; p_tx_data = 7'h00; p_rx_rd = 1'b0; p_err_clr = 1'b0; p_loop = 1'b1; p_drv = 1'b1;
      mon_sel = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_txd", 32'(a_txd), 32'd1);
      chk("rst_tx_empty", 32'(a_tx_empty), 32'd1);
      chk("rst_tx_full", 32'(a_tx_full), 32'd0);
      chk("rst_tx_busy", 32'(a_tx_busy), 32'd0);
      chk("rst_rx", pack(a_fe, a_pe, a_rx_data), 32'd0);
      chk("rst_rx_valid", 32'(a_rx_valid), 32'd0);
      chk("rst_ovr", 32'(a_ovr), 32'd0);
      chk("rst_p_txd", 32'(p_txd), 32'd1);
      reset = 1'b0;
      repeat (5) @(negedge clk);

      // 8N1 loopback, three back-to-back frames
      fork
         begin
            wait_start("lb");
            check_bits("lb55", frame_bits(8'h55, 8, 0), 10, 1'b0);
            check_bits("lbA3", frame_bits(8'hA3, 8, 0), 10, 1'b0);
            check_bits("lb00", frame_bits(8'h00, 8, 0), 10, 1'b1);
         end
         begin
            write_a(8'h55); exp_a.push_back(pack(1'b0, 1'b0, 8'h55));
            chk("lb_not_empty", 32'(a_tx_empty), 32'd0);
            write_a(8'hA3); exp_a.push_back(pack(1'b0, 1'b0, 8'hA3));
            write_a(8'h00); exp_a.push_back(pack(1'b0, 1'b0, 8'h00));
         end
      join
      chk("lb_txd_idle", 32'(a_txd), 32'd1);
      chk("lb_tx_empty", 32'(a_tx_empty), 32'd1);
      drain(1'b0, 3);

      // 7E2 loopback then a corrupted parity bit
      mon_sel = 1'b1;
      p_tx_data = 7'h41; p_tx_wr = 1'b1;
      @(negedge clk);
      p_tx_wr = 1'b0;
      exp_p.push_back(pack(1'b0, 1'b0, 8'h41));
      wait_start("par");
      check_bits("par41", frame_bits(8'h41, 7, 2), 11, 1'b1);
      drain(1'b1, 1);
      p_loop = 1'b0;
      fb = frame_bits(8'h41, 7, 2);
      fb[8] = ~fb[8];
      exp_p.push_back(pack(1'b0, 1'b1, 8'h41));
      drive_bits(1'b1, fb, 11);
      drain(1'b1, 1);
      p_loop = 1'b1;
      mon_sel = 1'b0;

      // Framing error: low stop bit is still pushed; then a short glitch is ignored
      a_loop = 1'b0;
      exp_a.push_back(pack(1'b1, 1'b0, 8'h3C));
      drive_bits(1'b0, frame_bits(8'h3C, 8, 0), 9);
      a_drv = 1'b0;
      repeat (48) @(negedge clk);
      a_drv = 1'b1;
      drain(1'b0, 1);
      repeat (200) @(negedge clk);
      a_drv = 1'b0;
      repeat (8) @(negedge clk);
      a_drv = 1'b1;
      repeat (800) @(negedge clk);
      chk("glitch_no_push", 32'(a_rx_valid), 32'd0);
      a_loop = 1'b1;

      // TX FIFO fill behind a busy transmitter; 17 frames back to back, RX overruns
      write_a(8'h00);
      exp_a.push_back(pack(1'b0, 1'b0, 8'h00));
      fork
         begin
            wait_start("fill");
            for (int f = 0; f <= 16; f++)
               check_bits($sformatf("fill%0d", f), frame_bits(8'(f), 8, 0), 10, f == 16);
         end
         begin
            w = 0;
            while (!a_tx_empty && w < 100) begin
               @(negedge clk);
               w++;
            end
            chk("fill_popped", 32'(a_tx_empty), 32'd1);
            for (int k = 0; k < 17; k++) begin
               chk($sformatf("fill_full%0d", k), 32'(a_tx_full), 32'(k >= 16));
               a_tx_data = 8'(k + 1);
               a_tx_wr   = 1'b1;
               if (k < 15) exp_a.push_back(pack(1'b0, 1'b0, 8'(k + 1)));
               @(negedge clk);
            end
            a_tx_wr = 1'b0;
            chk("fill_full_end", 32'(a_tx_full), 32'd1);
         end
      join
      repeat (320) @(negedge clk);
      chk("fill_no_extra", 32'(a_txd), 32'd1);
      chk("fill_tx_empty", 32'(a_tx_empty), 32'd1);
      chk("ovr_set", 32'(a_ovr), 32'd1);
      a_err_clr = 1'b1;
      @(negedge clk);
      a_err_clr = 1'b0;
      chk("ovr_clr", 32'(a_ovr), 32'd0);
      drain(1'b0, 16);
      chk("ovr_fifo_drained", 32'(a_rx_valid), 32'd0);

      // Reset in the middle of a TX frame with a second character queued
      write_a(8'h5A);
      wait_start("rst");
      write_a(8'h77);
      repeat (95) @(negedge clk);
      chk("rst_mid_low", 32'(a_txd), 32'd0);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_mid_txd", 32'(a_txd), 32'd1);
      chk("rst_mid_empty", 32'(a_tx_empty), 32'd1);
      chk("rst_mid_busy", 32'(a_tx_busy), 32'd0);
      chk("rst_mid_rx", 32'(a_rx_valid), 32'd0);
      reset = 1'b0;
      repeat (10) @(negedge clk);
      write_a(8'h96);
      exp_a.push_back(pack(1'b0, 1'b0, 8'h96));
      wait_start("post");
      check_bits("post96", frame_bits(8'h96, 8, 0), 10, 1'b1);
      drain(1'b0, 1);
      repeat (100) @(negedge clk);
      chk("post_no_partial", 32'(a_rx_valid), 32'd0);
      chk("sb_left", 32'(exp_a.size() + exp_p.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
